cache_control: RTL and testbench

- Two-way set-associative write-back cache controller for the LC-3b cache.
- Sits directly upstream of cache_datapath and drives its array write enables, data-in selects and physical-memory strobes.
- Consumes the datapath's hit/valid/dirty/LRU status for the indexed set.
- Sequences hit service, dirty-victim writeback and line allocation.
- Keeps saturating hit/miss counters.

---
 rtl/cache_control.sv | 170 +++++++++++++++++
 tb/tb_cache_control.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Control FSM for the two-way set-associative write-back LC-3b cache: hit service,
// dirty-victim writeback, line allocation, and saturating hit/miss counters.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 valid0,
    input  logic                 valid1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 lru,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic [1:0]           w_data,
    output logic [1:0]           w_tag,
    output logic [1:0]           w_valid,
    output logic [1:0]           w_dirty,
    output logic                 w_lru,
    output logic                 din_valid,
    output logic                 din_dirty,
    output logic                 din_lru,
    output logic                 data_sel,
    output logic [1:0]           addr_sel,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [1:0]           fsm_state  // 0 = IDLE, 1 = WRITEBACK, 2 = ALLOCATE
);

    // Handshakes: the CPU holds mem_read/mem_write until mem_resp is high for one cycle;
    // pmem_read/pmem_write stay high until pmem_resp, which completes the transfer that cycle.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_next;
    logic   victim;
    logic   refill;

    logic   req;
    logic   hit;
    logic   hit_way;
    logic   victim_dirty;
    logic   hit_inc;
    logic   miss_inc;
    logic   latch_victim;
    logic   refill_set;
    logic   refill_clr;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = ~hit0;
    assign victim_dirty = lru ? (valid1 & dirty1) : (valid0 & dirty0);
    assign fsm_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            victim <= 1'b0;
            refill <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_victim) victim <= lru;
            if (refill_set) refill <= 1'b1;
            else if (refill_clr) refill <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
            if (miss_inc && miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        w_data       = 2'b00;
        w_tag        = 2'b00;
        w_valid      = 2'b00;
        w_dirty      = 2'b00;
        w_lru        = 1'b0;
        din_valid    = 1'b0;
        din_dirty    = 1'b0;
        din_lru      = 1'b0;
        data_sel     = 1'b0;
        addr_sel     = 2'd0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        latch_victim = 1'b0;
        refill_set   = 1'b0;
        refill_clr   = 1'b0;

        case (state)
            IDLE: begin
                if (req && hit) begin
                    mem_resp   = 1'b1;
                    w_lru      = 1'b1;
                    din_lru    = ~hit_way;
                    // The hit that finishes a refill was already counted as a miss.
                    hit_inc    = ~refill;
                    refill_clr = 1'b1;
                    if (mem_write) begin
                        w_data    = hit_way ? 2'b10 : 2'b01;
                        w_dirty   = hit_way ? 2'b10 : 2'b01;
                        data_sel  = 1'b1;
                        din_dirty = 1'b1;
                    end
                end else if (req) begin
                    miss_inc     = 1'b1;
                    latch_victim = 1'b1;
                    state_next   = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = victim ? 2'd2 : 2'd1;
                if (pmem_resp) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_data     = victim ? 2'b10 : 2'b01;
                    w_tag      = victim ? 2'b10 : 2'b01;
                    w_valid    = victim ? 2'b10 : 2'b01;
                    w_dirty    = victim ? 2'b10 : 2'b01;
                    din_valid  = 1'b1;
                    refill_set = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reset silences every output at once, even mid-transaction.
        if (!rst_n) begin
            mem_resp   = 1'b0;
            w_data     = 2'b00;
            w_tag      = 2'b00;
            w_valid    = 2'b00;
            w_dirty    = 2'b00;
            w_lru      = 1'b0;
            din_valid  = 1'b0;
            din_dirty  = 1'b0;
            din_lru    = 1'b0;
            data_sel   = 1'b0;
            addr_sel   = 2'd0;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed scenarios plus randomized traffic, both checked
// every cycle against a transaction-level model; a 2-bit-counter copy exercises saturation.
module tb_cache_control;

    localparam int P_IDLE = 0;
    localparam int P_WB   = 1;
    localparam int P_AL   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0;
    logic hit0 = 1'b0, hit1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
    logic dirty0 = 1'b0, dirty1 = 1'b0, lru = 1'b0, pmem_resp = 1'b0;

    logic        mem_resp, w_lru, din_valid, din_dirty, din_lru, data_sel, pmem_read, pmem_write;
    logic [1:0]  w_data, w_tag, w_valid, w_dirty, addr_sel, fsm_state;
    logic [15:0] hit_count, miss_count;

    logic        s_mem_resp, s_w_lru, s_din_valid, s_din_dirty, s_din_lru, s_data_sel;
    logic        s_pmem_read, s_pmem_write;
    logic [1:0]  s_w_data, s_w_tag, s_w_valid, s_w_dirty, s_addr_sel, s_fsm_state;
    logic [1:0]  s_hit_count, s_miss_count;

    cache_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .w_data(w_data), .w_tag(w_tag), .w_valid(w_valid),
        .w_dirty(w_dirty), .w_lru(w_lru), .din_valid(din_valid), .din_dirty(din_dirty),
        .din_lru(din_lru), .data_sel(data_sel), .addr_sel(addr_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .hit_count(hit_count), .miss_count(miss_count), .fsm_state(fsm_state)
    );

    cache_control #(.CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(s_mem_resp), .w_data(s_w_data), .w_tag(s_w_tag), .w_valid(s_w_valid),
        .w_dirty(s_w_dirty), .w_lru(s_w_lru), .din_valid(s_din_valid), .din_dirty(s_din_dirty),
        .din_lru(s_din_lru), .data_sel(s_data_sel), .addr_sel(s_addr_sel),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .fsm_state(s_fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     ph   = P_IDLE;
    logic   vic  = 1'b0;
    logic   refl = 1'b0;
    longint nh   = 0;
    longint nm   = 0;

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [17:0] exp_ctrl();
        logic       resp, wl, dv, dd, dl, ds, pr, pw;
        logic [1:0] wd, wt, wv, wdy, as;
        logic       way;
        logic [1:0] one;
        resp = 0; wl = 0; dv = 0; dd = 0; dl = 0; ds = 0; pr = 0; pw = 0;
        wd = 0; wt = 0; wv = 0; wdy = 0; as = 0;
        if (rst_n) begin
            if (ph == P_IDLE && (mem_read || mem_write) && (hit0 || hit1)) begin
                way  = hit0 ? 1'b0 : 1'b1;
                one  = 2'b01 << way;
                resp = 1; wl = 1; dl = (way == 1'b0);
                if (mem_write) begin
                    wd = one; ds = 1; wdy = one; dd = 1;
                end
            end else if (ph == P_WB) begin
                pw = 1;
                as = 2'(int'(vic) + 1);
            end else if (ph == P_AL) begin
                pr = 1;
                if (pmem_resp) begin
                    one = 2'b01 << vic;
                    wd = one; wt = one; wv = one; wdy = one; dv = 1;
                end
            end
        end
        return {resp, wd, wt, wv, wdy, wl, dv, dd, dl, ds, as, pr, pw};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= P_IDLE; vic <= 1'b0; refl <= 1'b0; nh <= 0; nm <= 0;
        end else begin
            case (ph)
                P_IDLE: if (mem_read || mem_write) begin
                    if (hit0 || hit1) begin
                        if (!refl) nh <= nh + 1;
                        refl <= 1'b0;
                    end else begin
                        vic <= lru;
                        nm  <= nm + 1;
                        ph  <= (lru ? (valid1 && dirty1) : (valid0 && dirty0)) ? P_WB : P_AL;
                    end
                end
                P_WB: if (pmem_resp) ph <= P_AL;
                default: if (pmem_resp) begin
                    refl <= 1'b1;
                    ph   <= P_IDLE;
                end
            endcase
        end
    end

    logic [17:0] dut_ctrl, dut_s_ctrl;
    assign dut_ctrl   = {mem_resp, w_data, w_tag, w_valid, w_dirty, w_lru, din_valid,
                         din_dirty, din_lru, data_sel, addr_sel, pmem_read, pmem_write};
    assign dut_s_ctrl = {s_mem_resp, s_w_data, s_w_tag, s_w_valid, s_w_dirty, s_w_lru,
                         s_din_valid, s_din_dirty, s_din_lru, s_data_sel, s_addr_sel,
                         s_pmem_read, s_pmem_write};

    always @(negedge clk) begin
        chk("ctrl", dut_ctrl, exp_ctrl());
        chk("ctrl_w2", dut_s_ctrl, exp_ctrl());
        chk("state", fsm_state, ph);
        chk("hit_count", hit_count, sat(nh, 16));
        chk("miss_count", miss_count, sat(nm, 16));
        chk("hit_count_w2", s_hit_count, sat(nh, 2));
        chk("miss_count_w2", s_miss_count, sat(nm, 2));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic h0, input logic h1,
                          input logic v0, input logic v1, input logic d0, input logic d1,
                          input logic l, input logic pr);
        mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1;
        valid0 = v0; valid1 = v1; dirty0 = d0; dirty1 = d1; lru = l; pmem_resp = pr;
    endtask

    task automatic rand_in();
        int r;
        int h;
        r = $urandom_range(0, 9);
        mem_read  = (r < 5);
        mem_write = (r >= 4 && r < 8);
        h = $urandom_range(0, 19);
        hit0 = (h < 8) || (h == 19);
        hit1 = (h >= 8 && h < 16) || (h == 19);
        valid0 = 1'($urandom_range(0, 1));
        valid1 = 1'($urandom_range(0, 1));
        dirty0 = 1'($urandom_range(0, 1));
        dirty1 = 1'($urandom_range(0, 1));
        lru    = 1'($urandom_range(0, 1));
        pmem_resp = ($urandom_range(0, 2) == 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        look();
        chk("rst.mem_resp", mem_resp, 0);
        chk("rst.pmem_read", pmem_read, 0);
        chk("rst.hit_count", hit_count, 0);
        chk("rst.miss_count", miss_count, 0);
        #1 rst_n = 1'b1;
        tick();

        // read hit on way 0
        set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        look();
        chk("rd_hit.mem_resp", mem_resp, 1);
        chk("rd_hit.w_lru", w_lru, 1);
        chk("rd_hit.din_lru", din_lru, 1);
        chk("rd_hit.w_data", w_data, 2'b00);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        look();
        chk("rd_hit.hit_count", hit_count, 1);
        tick();

        // write hit on way 1
        set_in(0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        look();
        chk("wr_hit.mem_resp", mem_resp, 1);
        chk("wr_hit.w_data", w_data, 2'b10);
        chk("wr_hit.data_sel", data_sel, 1);
        chk("wr_hit.w_dirty", w_dirty, 2'b10);
        chk("wr_hit.din_dirty", din_dirty, 1);
        chk("wr_hit.din_lru", din_lru, 0);
        tick();

        // read miss with dirty victim in way 1
        set_in(1, 0, 0, 0, 1, 1, 1, 1, 1, 0);
        look();
        chk("dmiss.mem_resp", mem_resp, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            look();
            chk("dmiss.wb_pmem_write", pmem_write, 1);
            chk("dmiss.wb_addr_sel", addr_sel, 2);
            tick();
        end
        chk("dmiss.miss_count", miss_count, 1);
        pmem_resp = 1'b1;
        look();
        chk("dmiss.wb_last", pmem_write, 1);
        tick();
        pmem_resp = 1'b0;
        look();
        chk("dmiss.al_pmem_read", pmem_read, 1);
        chk("dmiss.al_addr_sel", addr_sel, 0);
        chk("dmiss.al_pmem_write", pmem_write, 0);
        tick();
        pmem_resp = 1'b1;
        look();
        chk("dmiss.fill_w_data", w_data, 2'b10);
        chk("dmiss.fill_w_tag", w_tag, 2'b10);
        chk("dmiss.fill_w_valid", w_valid, 2'b10);
        chk("dmiss.fill_w_dirty", w_dirty, 2'b10);
        chk("dmiss.fill_din_dirty", din_dirty, 0);
        chk("dmiss.fill_din_valid", din_valid, 1);
        tick();
        set_in(1, 0, 0, 1, 1, 1, 0, 0, 1, 0);
        look();
        chk("dmiss.final_resp", mem_resp, 1);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        look();
        chk("dmiss.hit_count", hit_count, 2);
        tick();

        // write miss, clean victim in way 0
        set_in(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        look();
        chk("cmiss.mem_resp", mem_resp, 0);
        tick();
        look();
        chk("cmiss.pmem_write", pmem_write, 0);
        chk("cmiss.pmem_read", pmem_read, 1);
        tick();
        pmem_resp = 1'b1;
        look();
        chk("cmiss.fill_w_valid", w_valid, 2'b01);
        tick();
        set_in(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        look();
        chk("cmiss.merge_w_dirty", w_dirty, 2'b01);
        chk("cmiss.merge_din_dirty", din_dirty, 1);
        chk("cmiss.merge_w_data", w_data, 2'b01);
        tick();

        // saturation of the 2-bit copy
        set_in(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        look();
        chk("sat.hit_count", hit_count, 7);
        chk("sat.hit_count_w2", s_hit_count, 3);
        chk("sat.miss_count_w2", s_miss_count, 2);
        tick();

        // reset in the middle of an allocate
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        look();
        chk("rst_mid.pmem_read_before", pmem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.pmem_read", pmem_read, 0);
        chk("rst_mid.state", fsm_state, P_IDLE);
        chk("rst_mid.hit_count", hit_count, 0);
        chk("rst_mid.miss_count", miss_count, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            rand_in();
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
